// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared types and constants for the UART byte path.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        SEND  = 2'd3
    } fifo_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Single-clock circular FIFO with explicit occupancy counter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH  = BYTE_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_count_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == c_full_count);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_rx_fifo
// Brief  : Buffers received bytes and drains them into uart_tx one at a time.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud,
    input  logic              rx_done,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    fifo_state_t       r_state;
    fifo_state_t       w_next_state;
    logic              r_tx_start;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_overflow;

    logic              w_pop;
    logic              w_drop;
    logic [BYTE_W-1:0] w_fifo_data;
    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;

    sync_fifo #(
        .WIDTH  (BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_done),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = (r_state == LOAD) && !w_empty;
    assign w_drop = rx_done && w_full && !w_pop;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty && !tx_busy) w_next_state = LOAD;
            LOAD:    w_next_state = w_empty ? IDLE : START;
            START:   if (baud) w_next_state = SEND;
            SEND:    if (tx_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // tx_start is registered from the next state so it is high exactly while in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx_start <= (w_next_state == START);
            if (w_pop) begin
                r_tx_data <= w_fifo_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign count    = w_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire
